cluster_frame_io: RTL

- Feeds one frame to a learned-logic cluster and returns its result.
- Load side: collects a 32-bit word stream into the 1894-bit cluster input vector.
- Evaluate side: holds the vector stable for a fixed settle time, then samples the cluster's output bits (the module_output_bit_* outputs, concatenated).
- Return side: streams the sampled result back as 32-bit words.
- Sits between the host/testbench stream fabric and a combinational cluster instance, which it drives.

---
 rtl/cluster_frame_io.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cluster_frame_io.sv
// Frame adapter for a combinational learned-logic cluster: packs a word stream
// into the cluster input vector, waits a fixed settle time, and streams the sampled result back.
module cluster_frame_io #(
  parameter int IN_W     = 1894,
  parameter int OUT_W    = 128,
  parameter int WORD_W   = 32,
  parameter int EVAL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic [IN_W-1:0]   vec_o,
  input  logic [OUT_W-1:0]  res_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_err,
  output logic              busy
);

  localparam int NW_IN  = (IN_W + WORD_W - 1) / WORD_W;
  localparam int NW_OUT = OUT_W / WORD_W;
  localparam int WCNT_W = (NW_IN > 1) ? $clog2(NW_IN) : 1;
  localparam int OCNT_W = (NW_OUT > 1) ? $clog2(NW_OUT) : 1;
  localparam int ECNT_W = 4;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    EVAL,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
  logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
  logic                err_q, err_d;
  logic [IN_W-1:0]     vec_q;
  logic [OUT_W-1:0]    res_q;

  logic s_accept;
  logic s_fire;
  logic m_fire;
  logic load_wr;
  logic capture;
  logic last_in_word;
  logic last_out_word;

  assign s_accept      = (state_q == LOAD) || (state_q == DRAIN);
  assign s_fire        = s_valid && s_accept;
  assign m_fire        = m_ready && (state_q == SEND);
  assign load_wr       = s_fire && (state_q == LOAD);
  assign capture       = (state_q == EVAL) && (ecnt_q == ECNT_W'(EVAL_LAT - 1));
  assign last_in_word  = (wcnt_q == WCNT_W'(NW_IN - 1));
  assign last_out_word = (ocnt_q == OCNT_W'(NW_OUT - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    ocnt_d  = ocnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (s_fire) begin
          if (last_in_word) begin
            wcnt_d = '0;
            if (s_last) begin
              state_d = EVAL;
              ecnt_d  = '0;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            err_d  = 1'b1;
            wcnt_d = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (s_fire && s_last) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end
      end
      EVAL: begin
        ecnt_d = ecnt_q + 1'b1;
        if (capture) begin
          state_d = SEND;
          ocnt_d  = '0;
        end
      end
      SEND: begin
        if (m_fire) begin
          if (last_out_word) begin
            state_d = LOAD;
            wcnt_d  = '0;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
      ocnt_q  <= '0;
      err_q   <= 1'b0;
      // NOTE: the vector drives the cluster directly, so it is a reset register, not an unreset storage array.
      vec_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
      ocnt_q  <= ocnt_d;
      err_q   <= err_d;
      // Word k lands at bits [WORD_W*k +: WORD_W]; bits past IN_W simply have no destination.
      if (load_wr) begin
        for (int i = 0; i < IN_W; i++) begin
          if (WCNT_W'(i / WORD_W) == wcnt_q) vec_q[i] <= s_data[i % WORD_W];
        end
      end
      if (capture) res_q <= res_i;
    end
  end

  assign s_ready   = s_accept && !rst;
  assign vec_o     = vec_q;
  assign m_valid   = (state_q == SEND);
  assign m_last    = (state_q == SEND) && last_out_word;
  assign m_data    = res_q[WORD_W*ocnt_q +: WORD_W];
  assign frame_err = err_q;
  assign busy      = (state_q != LOAD);

endmodule
